sa_output_collector: RTL

- Sits directly downstream of the systolic array.
- Captures result rows emitted by the array (out_en / row_out / array_output) into a double-buffered tile store.
- Streams each completed tile to memory writeback one row per beat over a valid/ready interface.
- Drives stall_sa back to the array when no tile buffer is free.

---
 rtl/sys_arr_pkg.sv | 20 ++
 rtl/sa_tile_buffer.sv | 57 +++++
 rtl/sa_output_collector.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/sys_arr_pkg.sv
// Shared sizes and types for the systolic array and its output collector.
package sys_arr_pkg;

    localparam int unsigned N    = 4;
    localparam int unsigned DW   = 16;
    localparam int unsigned NBUF = 2;
    localparam int unsigned RW   = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned RDW  = DW * N;

    typedef logic [RDW-1:0]        row_t;
    typedef logic [RW-1:0]         row_idx_t;
    typedef logic [N-1:0]          row_mask_t;
    typedef logic [N-1:0][RDW-1:0] tile_t;

    typedef enum logic {
        RD_IDLE   = 1'b0,
        RD_STREAM = 1'b1
    } rd_state_t;

endpackage

// File: rtl/sa_tile_buffer.sv
// One tile store: row-indexed write port with arrival bitmap and full flag, plus one read port.
module sa_tile_buffer
    import sys_arr_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      wr_en,
    input  row_idx_t  wr_idx,
    input  row_t      wr_data,
    input  logic      set_full,
    input  logic      clr,
    input  row_idx_t  rd_idx,
    output row_t      rd_data,
    output row_mask_t bitmap,
    output logic      full
);

    tile_t     mem_q, mem_d;
    row_mask_t bitmap_q, bitmap_d;
    logic      full_q, full_d;

    // Row write, completion marking and release; clear wins since it only hits a full buffer.
    always_comb begin
        mem_d    = mem_q;
        bitmap_d = bitmap_q;
        full_d   = full_q;
        if (wr_en) begin
            mem_d[wr_idx]    = wr_data;
            bitmap_d[wr_idx] = 1'b1;
        end
        if (set_full) begin
            full_d = 1'b1;
        end
        if (clr) begin
            bitmap_d = '0;
            full_d   = 1'b0;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q    <= '0;
            bitmap_q <= '0;
            full_q   <= 1'b0;
        end else begin
            mem_q    <= mem_d;
            bitmap_q <= bitmap_d;
            full_q   <= full_d;
        end
    end

    assign rd_data = mem_q[rd_idx];
    assign bitmap  = bitmap_q;
    assign full    = full_q;

endmodule

// File: rtl/sa_output_collector.sv
// Collects systolic-array result rows into two tile buffers and streams full tiles to writeback.
module sa_output_collector
    import sys_arr_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     out_en,
    input  row_idx_t row_out,
    input  row_t     array_output,
    output logic     stall_sa,
    output logic     wr_valid,
    input  logic     wr_ready,
    output row_idx_t wr_row,
    output row_t     wr_data,
    output logic     wr_last,
    output logic     tile_done,
    output logic     err_dup,
    output logic     err_drop,
    input  logic     err_clr
);

    logic      fb_q, fb_d;
    logic      rb_q, rb_d;
    rd_state_t state_q, state_d;
    row_idx_t  cnt_q, cnt_d;
    logic      tile_done_q, tile_done_d;
    logic      err_dup_q, err_dup_d;
    logic      err_drop_q, err_drop_d;

    logic [NBUF-1:0] b_wr_en, b_set_full, b_clr, b_full;
    row_mask_t       b_bitmap  [NBUF];
    row_t            b_rd_data [NBUF];

    logic      wr_accept, dup_hit, completes, beat_last, release_buf;
    row_mask_t fill_mask, row_bit;

    // Two tile buffers, one filling while the other drains.
    for (genvar g = 0; g < NBUF; g++) begin : g_buf
        sa_tile_buffer u_buf (
            .clk      (clk),
            .rst      (rst),
            .wr_en    (b_wr_en[g]),
            .wr_idx   (row_out),
            .wr_data  (array_output),
            .set_full (b_set_full[g]),
            .clr      (b_clr[g]),
            .rd_idx   (cnt_q),
            .rd_data  (b_rd_data[g]),
            .bitmap   (b_bitmap[g]),
            .full     (b_full[g])
        );
    end

    // Fill-side decode; stall comes only from registered full flags.
    always_comb begin
        stall_sa    = b_full[fb_q];
        wr_accept   = out_en && !stall_sa;
        fill_mask   = b_bitmap[fb_q];
        row_bit     = row_mask_t'(1) << row_out;
        dup_hit     = wr_accept && ((fill_mask & row_bit) != '0);
        completes   = wr_accept && ((fill_mask | row_bit) == '1);
        beat_last   = (cnt_q == row_idx_t'(N - 1));
        release_buf = (state_q == RD_STREAM) && wr_ready && beat_last;
        for (int unsigned i = 0; i < NBUF; i++) begin
            b_wr_en[i]    = wr_accept && (fb_q == 1'(i));
            b_set_full[i] = completes && (fb_q == 1'(i));
            b_clr[i]      = release_buf && (rb_q == 1'(i));
        end
    end

    // Pointer, read FSM, beat counter and sticky error next-state.
    always_comb begin
        fb_d        = fb_q;
        rb_d        = rb_q;
        state_d     = state_q;
        cnt_d       = cnt_q;
        tile_done_d = 1'b0;
        err_dup_d   = err_clr ? 1'b0 : err_dup_q;
        err_drop_d  = err_clr ? 1'b0 : err_drop_q;

        if (completes) begin
            fb_d = ~fb_q;
        end
        if (dup_hit) begin
            err_dup_d = 1'b1;
        end
        if (out_en && stall_sa) begin
            err_drop_d = 1'b1;
        end

        case (state_q)
            RD_IDLE: begin
                cnt_d = '0;
                if (b_full[rb_q]) begin
                    state_d = RD_STREAM;
                end
            end
            RD_STREAM: begin
                if (wr_ready) begin
                    if (beat_last) begin
                        cnt_d       = '0;
                        rb_d        = ~rb_q;
                        tile_done_d = 1'b1;
                        state_d     = RD_IDLE;
                    end else begin
                        cnt_d = cnt_q + row_idx_t'(1);
                    end
                end
            end
            default: begin
                state_d = RD_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Control registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            fb_q        <= 1'b0;
            rb_q        <= 1'b0;
            state_q     <= RD_IDLE;
            cnt_q       <= '0;
            tile_done_q <= 1'b0;
            err_dup_q   <= 1'b0;
            err_drop_q  <= 1'b0;
        end else begin
            fb_q        <= fb_d;
            rb_q        <= rb_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            tile_done_q <= tile_done_d;
            err_dup_q   <= err_dup_d;
            err_drop_q  <= err_drop_d;
        end
    end

    assign wr_valid  = (state_q == RD_STREAM);
    assign wr_row    = cnt_q;
    assign wr_last   = wr_valid && beat_last;
    assign wr_data   = wr_valid ? b_rd_data[rb_q] : '0;
    assign tile_done = tile_done_q;
    assign err_dup   = err_dup_q;
    assign err_drop  = err_drop_q;

endmodule
